decode_regfile_stage: RTL and testbench

Pipelined decode stage for the RV32I core: fields and immediate are extracted from one instruction per cycle, and the register file (XLEN × NREGS) is read behind a valid/ready output register. The stage has write-back bypass, stall-time operand refresh and a flush input. It sits between fetch and the ALU/memory stage and replaces the unregistered decoder/register-file pair.

---
 rtl/decode_regfile_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_regfile_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_stage.sv
// RV32I decode stage: field/immediate extraction and register-file read
// behind a valid/ready output register, with write-back bypass and stall refresh.
module decode_regfile_stage #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_reg1,
    output logic [XLEN-1:0] out_reg2,
    output logic [XLEN-1:0] out_immediate,
    output logic            out_illegal
);

    localparam int         AW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];

    logic            r_valid;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_reg1;
    logic [XLEN-1:0] r_reg2;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_wr_ok;
    logic            w_accept;
    logic            w_illegal;

    function automatic logic idx_ok(input logic [4:0] a);
        return {1'b0, a} < NR;
    endfunction

    // Legal write: in range and not targeting a hardwired x0.
    assign w_wr_ok = wb_en && idx_ok(wb_addr)
                     && !(ZERO_REG && wb_addr == 5'd0);

    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (!idx_ok(a) || (ZERO_REG && a == 5'd0))
            v = '0;
        else if (w_wr_ok && wb_addr == a)
            v = wb_data;
        else
            v = r_regs[a[AW-1:0]];
        return v;
    endfunction

    assign w_opcode  = instruction[6:0];
    assign w_rd      = instruction[11:7];
    assign w_rs1     = instruction[19:15];
    assign w_rs2     = instruction[24:20];
    assign w_rd1     = rd_port(w_rs1);
    assign w_rd2     = rd_port(w_rs2);
    assign w_illegal = !idx_ok(w_rs1) || !idx_ok(w_rs2) || !idx_ok(w_rd);

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;

    always_comb begin
        w_imm32 = '0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111:
                w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            7'b0100011:
                w_imm32 = {{20{instruction[31]}}, instruction[31:25],
                           instruction[11:7]};
            7'b1100011:
                w_imm32 = {{19{instruction[31]}}, instruction[31],
                           instruction[7], instruction[30:25],
                           instruction[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                w_imm32 = {instruction[31:12], 12'b0};
            7'b1101111:
                w_imm32 = {{11{instruction[31]}}, instruction[31],
                           instruction[19:12], instruction[20],
                           instruction[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_opcode  <= w_opcode;
            r_funct3  <= instruction[14:12];
            r_funct7  <= instruction[31:25];
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_reg1    <= w_rd1;
            r_reg2    <= w_rd2;
            r_imm     <= XLEN'($signed(w_imm32));
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end else if (r_valid && w_wr_ok) begin
            // Held bundle tracks writes so it never carries a stale operand.
            if (wb_addr == r_rs1)
                r_reg1 <= wb_data;
            if (wb_addr == r_rs2)
                r_reg2 <= wb_data;
        end
    end

    assign out_valid     = r_valid;
    assign out_opcode    = r_opcode;
    assign out_funct3    = r_funct3;
    assign out_funct7    = r_funct7;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rd        = r_rd;
    assign out_reg1      = r_reg1;
    assign out_reg2      = r_reg2;
    assign out_immediate = r_imm;
    assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed bench for decode_regfile_stage: an RV32I instance plus an
// RV32E (NREGS=16) instance sharing the same stimulus.
module tb_decode_regfile_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, wb_en, out_ready;
    logic [31:0] instruction, wb_data;
    logic [4:0]  wb_addr;

    logic        in_ready, out_valid, out_illegal;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_reg1, out_reg2, out_immediate;

    logic        e_in_ready, e_valid, e_illegal;
    logic [6:0]  e_opcode, e_funct7;
    logic [2:0]  e_funct3;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_reg1, e_reg2, e_imm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_regfile_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_immediate(out_immediate), .out_illegal(out_illegal)
    );

    decode_regfile_stage #(.NREGS(16)) u_rve (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
        .instruction(instruction), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(e_valid),
        .out_ready(out_ready), .out_opcode(e_opcode),
        .out_funct3(e_funct3), .out_funct7(e_funct7),
        .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd),
        .out_reg1(e_reg1), .out_reg2(e_reg2),
        .out_immediate(e_imm), .out_illegal(e_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; out_ready = 1;
        wb_addr = 0; wb_data = 0; instruction = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%h exp=1", in_ready); end
        checks++; if ({out_opcode, out_rd, out_reg1, out_immediate} !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {out_opcode, out_rd, out_reg1, out_immediate}); end
    endtask

    task automatic test_add();
        wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
        step();
        wb_addr = 1; wb_data = 32'h5;
        step();
        wb_en = 0; in_valid = 1; instruction = add(5'd2, 5'd3, 5'd1);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%h exp=1", out_valid); end
        checks++; if ({out_rs1, out_rs2, out_rd} !== {5'd3, 5'd1, 5'd2}) begin failures++; $display("FAIL add_idx got=%h exp=%h", {out_rs1, out_rs2, out_rd}, {5'd3, 5'd1, 5'd2}); end
        checks++; if (out_reg1 !== 32'hAA || out_reg2 !== 32'h5) begin failures++; $display("FAIL add_ops got=%h/%h exp=aa/5", out_reg1, out_reg2); end
        checks++; if (out_opcode !== 7'b0110011 || out_immediate !== 32'h0) begin failures++; $display("FAIL add_rtype got=%h/%h exp=33/0", out_opcode, out_immediate); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%h exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        in_valid = 1; instruction = 32'h0FF1_8213;
        wb_en = 1; wb_addr = 3; wb_data = 32'h1234;
        step();
        idle();
        checks++; if (out_reg1 !== 32'h1234) begin failures++; $display("FAIL bypass_reg1 got=%h exp=1234", out_reg1); end
        checks++; if (out_immediate !== 32'hFF || out_rd !== 5'd4) begin failures++; $display("FAIL bypass_imm got=%h/%h exp=ff/4", out_immediate, out_rd); end
        step();
    endtask

    task automatic test_stall_refresh();
        out_ready = 0; in_valid = 1; instruction = addi(5'd5, 5'd1, 12'd0);
        step();
        checks++; if (out_valid !== 1'b1 || out_reg1 !== 32'h5) begin failures++; $display("FAIL stall_load got=%h/%h exp=1/5", out_valid, out_reg1); end
        instruction = add(5'd2, 5'd3, 5'd1);
        wb_en = 1; wb_addr = 1; wb_data = 32'hDEAD;
        step();
        wb_en = 0;
        checks++; if (out_reg1 !== 32'hDEAD || out_valid !== 1'b1) begin failures++; $display("FAIL stall_refresh got=%h/%h exp=dead/1", out_reg1, out_valid); end
        checks++; if (in_ready !== 1'b0 || out_rd !== 5'd5) begin failures++; $display("FAIL stall_hold got=%h/%h exp=0/5", in_ready, out_rd); end
        out_ready = 1;
        step();
        checks++; if (out_rd !== 5'd2 || out_reg1 !== 32'h1234 || out_reg2 !== 32'hDEAD) begin failures++; $display("FAIL stall_next got=%h/%h/%h exp=2/1234/dead", out_rd, out_reg1, out_reg2); end
        instruction = add(5'd2, 5'd1, 5'd1);
        step();
        out_ready = 0; in_valid = 0;
        wb_en = 1; wb_addr = 1; wb_data = 32'hBEEF;
        step();
        checks++; if (out_reg1 !== 32'hBEEF || out_reg2 !== 32'hBEEF) begin failures++; $display("FAIL stall_both got=%h/%h exp=beef/beef", out_reg1, out_reg2); end
        idle();
        step();
    endtask

    task automatic test_x0();
        in_valid = 1; instruction = addi(5'd5, 5'd0, 12'd0);
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
        step();
        wb_en = 0;
        checks++; if (out_reg1 !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", out_reg1); end
        step();
        idle();
        checks++; if (out_reg1 !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", out_reg1); end
        step();
    endtask

    task automatic test_rv32e();
        wb_en = 1; wb_addr = 20; wb_data = 32'h55;
        step();
        wb_en = 0; in_valid = 1; instruction = addi(5'd1, 5'd20, 12'd0);
        step();
        idle();
        checks++; if (e_reg1 !== 32'h0 || e_illegal !== 1'b1) begin failures++; $display("FAIL rve_x20 got=%h/%h exp=0/1", e_reg1, e_illegal); end
        checks++; if (out_reg1 !== 32'h55 || out_illegal !== 1'b0) begin failures++; $display("FAIL rvi_x20 got=%h/%h exp=55/0", out_reg1, out_illegal); end
        step();
    endtask

    task automatic test_immediates();
        in_valid = 1; instruction = 32'hFE00_0EE3;
        step();
        checks++; if (out_immediate !== 32'hFFFF_FFFC) begin failures++; $display("FAIL imm_b got=%h exp=fffffffc", out_immediate); end
        instruction = 32'h8000_0037;
        step();
        checks++; if (out_immediate !== 32'h8000_0000) begin failures++; $display("FAIL imm_u got=%h exp=80000000", out_immediate); end
        instruction = {7'b1111111, 5'd1, 5'd2, 3'b010, 5'b11100, 7'b0100011};
        step();
        checks++; if (out_immediate !== 32'hFFFF_FFFC) begin failures++; $display("FAIL imm_s got=%h exp=fffffffc", out_immediate); end
        instruction = {1'b1, 10'b1111111100, 1'b1, 8'hFF, 5'd0, 7'b1101111};
        step();
        checks++; if (out_immediate !== 32'hFFFF_FFF8) begin failures++; $display("FAIL imm_j got=%h exp=fffffff8", out_immediate); end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            instruction = addi(5'(10 + i), 5'd0, 12'(10 + i));
            step();
            checks++; if (out_valid !== 1'b1 || out_rd !== 5'(10 + i) || out_immediate !== 32'(10 + i)) begin failures++; $display("FAIL b2b_%0d got=%h/%h/%h exp=1/%h/%h", i, out_valid, out_rd, out_immediate, 5'(10 + i), 32'(10 + i)); end
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%h exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; instruction = addi(5'd7, 5'd0, 12'd1);
        step();
        flush = 1; instruction = addi(5'd8, 5'd0, 12'd2);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%h exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stall got=%h exp=0", out_valid); end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%h exp=0", out_valid); end
        idle();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%h exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        wb_en = 1; wb_addr = 7; wb_data = 32'h77;
        step();
        wb_en = 0; out_ready = 0; in_valid = 1;
        instruction = addi(5'd5, 5'd7, 12'd0);
        step();
        checks++; if (out_reg1 !== 32'h77) begin failures++; $display("FAIL rstmid_pre got=%h exp=77", out_reg1); end
        rst = 1; wb_en = 1; wb_addr = 7; wb_data = 32'h99;
        step();
        rst = 0; wb_en = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_reg1 !== 32'h0 || out_rs1 !== 5'd0) begin failures++; $display("FAIL rstmid_out got=%h/%h/%h exp=0/0/0", out_valid, out_reg1, out_rs1); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%h exp=1", in_ready); end
        out_ready = 1; in_valid = 1; instruction = add(5'd2, 5'd7, 5'd3);
        step();
        idle();
        checks++; if (out_reg1 !== 32'h0 || out_reg2 !== 32'h0) begin failures++; $display("FAIL rstmid_regs got=%h/%h exp=0/0", out_reg1, out_reg2); end
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_add();
        test_bypass();
        test_stall_refresh();
        test_x0();
        test_rv32e();
        test_immediates();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
